// File: rtl/vga_sprite_renderer.sv
// Pixel-colour stage for a 640x480 VGA timing generator: selectable background,
// bouncing square sprite, RGB565 output and syncs delayed to match a 2-stage pipeline.
module vga_sprite_renderer #(
    parameter int unsigned BoxSize = 32,
    parameter int unsigned StepX   = 2,
    parameter int unsigned StepY   = 1
) (
    input  logic       Clock25,
    input  logic       Reset,
    input  logic [9:0] HorizontalCounter,
    input  logic [9:0] VerticalCounter,
    input  logic       HorizontalSync,
    input  logic       VerticalSync,
    input  logic [1:0] Mode,
    input  logic       Freeze,
    output logic       HSyncOut,
    output logic       VSyncOut,
    output logic       DataEnable,
    output logic [4:0] Red,
    output logic [5:0] Green,
    output logic [4:0] Blue,
    output logic       FrameStrobe
);
    typedef enum logic [1:0] {
        MODE_BLACK    = 2'd0,
        MODE_BARS     = 2'd1,
        MODE_CHECKER  = 2'd2,
        MODE_GRADIENT = 2'd3
    } bg_mode_e;

    localparam logic [10:0] MAX_X  = 11'(640 - BoxSize);
    localparam logic [10:0] MAX_Y  = 11'(480 - BoxSize);
    localparam logic [10:0] BOX_W  = 11'(BoxSize);
    localparam logic [10:0] STEP_X = 11'(StepX);
    localparam logic [10:0] STEP_Y = 11'(StepY);

    // Bounce one axis; result is {new_dir, new_pos}.
    function automatic logic [10:0] bounce(input logic [9:0] pos, input logic dir,
                                           input logic [10:0] step, input logic [10:0] max_pos);
        logic [10:0] ext;
        logic [10:0] sum;
        logic [10:0] res;
        ext = {1'b0, pos};
        sum = ext + step;
        if (dir) begin
            if (sum >= max_pos) res = {1'b0, max_pos[9:0]};
            else                res = {1'b1, sum[9:0]};
        end else begin
            if (ext <= step)    res = {1'b1, 10'd0};
            else                res = {1'b0, 10'(ext - step)};
        end
        return res;
    endfunction

    // Sprite / frame state
    logic [9:0] box_x_q, box_x_d, box_y_q, box_y_d;
    logic       dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    bg_mode_e   mode_q, mode_d;
    logic       frame_strobe_q, frame_strobe_d;
    logic       frame_event;

    // Stage 1
    logic       vis_q, vis_d, inside_q, inside_d, checker_q, checker_d;
    logic [2:0] bar_q, bar_d;
    logic [4:0] grad_r_q, grad_r_d;
    logic [5:0] grad_g_q, grad_g_d;
    logic       hsync_s1_q, vsync_s1_q;
    logic [9:0] x_d, y_d;
    logic [10:0] x11, y11, bx11, by11;

    // Stage 2
    logic        de_q;
    logic [15:0] rgb_q, rgb_d;
    logic        hsync_s2_q, vsync_s2_q;

    always_comb begin
        frame_event    = (HorizontalCounter == 10'd1) && (VerticalCounter == 10'd481);
        box_x_d        = box_x_q;
        box_y_d        = box_y_q;
        dir_x_d        = dir_x_q;
        dir_y_d        = dir_y_q;
        mode_d         = mode_q;
        frame_strobe_d = frame_event;
        if (frame_event) begin
            mode_d = bg_mode_e'(Mode);
            if (!Freeze) begin
                {dir_x_d, box_x_d} = bounce(box_x_q, dir_x_q, STEP_X, MAX_X);
                {dir_y_d, box_y_d} = bounce(box_y_q, dir_y_q, STEP_Y, MAX_Y);
            end
        end
    end

    always_comb begin
        vis_d = (HorizontalCounter >= 10'd1) && (HorizontalCounter <= 10'd640) &&
                (VerticalCounter >= 10'd1) && (VerticalCounter <= 10'd480);
        x_d   = HorizontalCounter - 10'd1;
        y_d   = VerticalCounter - 10'd1;
        x11   = {1'b0, x_d};
        y11   = {1'b0, y_d};
        bx11  = {1'b0, box_x_q};
        by11  = {1'b0, box_y_q};
        // 11-bit compares keep BoxX+BoxSize from wrapping near the right edge
        inside_d  = (x11 >= bx11) && (x11 < bx11 + BOX_W) &&
                    (y11 >= by11) && (y11 < by11 + BOX_W);
        bar_d     = 3'(x_d / 10'd80);
        checker_d = x_d[4] ^ y_d[4];
        grad_r_d  = x_d[9:5];
        grad_g_d  = y_d[8:3];
    end

    always_comb begin
        rgb_d = '0;
        if (vis_q) begin
            if (inside_q) begin
                rgb_d = '1;
            end else begin
                case (mode_q)
                    MODE_BLACK: rgb_d = '0;
                    MODE_BARS: begin
                        case (bar_q)
                            3'd0:    rgb_d = 16'hFFFF;
                            3'd1:    rgb_d = 16'hFFE0;
                            3'd2:    rgb_d = 16'h07FF;
                            3'd3:    rgb_d = 16'h07E0;
                            3'd4:    rgb_d = 16'hF81F;
                            3'd5:    rgb_d = 16'hF800;
                            3'd6:    rgb_d = 16'h001F;
                            default: rgb_d = 16'h0000;
                        endcase
                    end
                    MODE_CHECKER:  rgb_d = checker_q ? 16'h0000 : 16'hFFFF;
                    MODE_GRADIENT: rgb_d = {grad_r_q, grad_g_q, 5'd0};
                    default:       rgb_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge Clock25) begin
        if (Reset) begin
            box_x_q        <= '0;
            box_y_q        <= '0;
            dir_x_q        <= 1'b1;
            dir_y_q        <= 1'b1;
            mode_q         <= MODE_BLACK;
            frame_strobe_q <= 1'b0;
            vis_q          <= 1'b0;
            inside_q       <= 1'b0;
            checker_q      <= 1'b0;
            bar_q          <= '0;
            grad_r_q       <= '0;
            grad_g_q       <= '0;
            hsync_s1_q     <= 1'b1;
            vsync_s1_q     <= 1'b1;
            de_q           <= 1'b0;
            rgb_q          <= '0;
            hsync_s2_q     <= 1'b1;
            vsync_s2_q     <= 1'b1;
        end else begin
            box_x_q        <= box_x_d;
            box_y_q        <= box_y_d;
            dir_x_q        <= dir_x_d;
            dir_y_q        <= dir_y_d;
            mode_q         <= mode_d;
            frame_strobe_q <= frame_strobe_d;
            vis_q          <= vis_d;
            inside_q       <= inside_d;
            checker_q      <= checker_d;
            bar_q          <= bar_d;
            grad_r_q       <= grad_r_d;
            grad_g_q       <= grad_g_d;
            hsync_s1_q     <= HorizontalSync;
            vsync_s1_q     <= VerticalSync;
            de_q           <= vis_q;
            rgb_q          <= rgb_d;
            hsync_s2_q     <= hsync_s1_q;
            vsync_s2_q     <= vsync_s1_q;
        end
    end

    assign HSyncOut    = hsync_s2_q;
    assign VSyncOut    = vsync_s2_q;
    assign DataEnable  = de_q;
    assign Red         = rgb_q[15:11];
    assign Green       = rgb_q[10:5];
    assign Blue        = rgb_q[4:0];
    assign FrameStrobe = frame_strobe_q;
endmodule

// File: tb/tb_vga_sprite_renderer.sv
// Self-checking bench for vga_sprite_renderer: a frame-level reference model predicts
// every output cycle while directed and random counter sequences are applied.
module tb_vga_sprite_renderer;
    localparam int BOX  = 32;
    localparam int SX   = 2;
    localparam int SY   = 1;
    localparam int MAXX = 640 - BOX;
    localparam int MAXY = 480 - BOX;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] hc = '0, vc = '0;
    logic       hs_in = 1'b1, vs_in = 1'b1;
    logic [1:0] mode = '0;
    logic       frz = 1'b0;
    logic       HSyncOut, VSyncOut, DataEnable, FrameStrobe;
    logic [4:0] Red, Blue;
    logic [5:0] Green;
    logic [19:0] dut_vec;

    int checks = 0;
    int errors = 0;

    vga_sprite_renderer #(.BoxSize(BOX), .StepX(SX), .StepY(SY)) dut (
        .Clock25(clk), .Reset(rst), .HorizontalCounter(hc), .VerticalCounter(vc),
        .HorizontalSync(hs_in), .VerticalSync(vs_in), .Mode(mode), .Freeze(frz),
        .HSyncOut(HSyncOut), .VSyncOut(VSyncOut), .DataEnable(DataEnable),
        .Red(Red), .Green(Green), .Blue(Blue), .FrameStrobe(FrameStrobe)
    );

    always #5 clk = ~clk;
    assign dut_vec = {HSyncOut, VSyncOut, DataEnable, FrameStrobe, Red, Green, Blue};

    // Reference model: sprite position/direction, latched mode, one pending pixel.
    int   m_bx = 0, m_by = 0, m_mode = 0;
    bit   m_dx = 1, m_dy = 1;
    bit   p_vis = 0, p_in = 0, p_hs = 1, p_vs = 1;
    int   p_x = 0, p_y = 0;
    logic [19:0] exp_vec = 20'hC0000;
    logic [15:0] bar_tab [0:7] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                   16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    function automatic logic [15:0] colour(bit vis, bit inb, int x, int y, int md);
        logic [4:0] r;
        logic [5:0] g;
        if (!vis) return 16'h0000;
        if (inb)  return 16'hFFFF;
        case (md)
            1: return bar_tab[x / 80];
            2: return ((((x >> 4) ^ (y >> 4)) & 1) == 0) ? 16'hFFFF : 16'h0000;
            3: begin
                r = 5'((x >> 5) & 31);
                g = 6'((y >> 3) & 63);
                return {r, g, 5'd0};
            end
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_edge();
        int h, v;
        bit ev;
        h  = int'(hc);
        v  = int'(vc);
        ev = (h == 1) && (v == 481);
        if (rst) begin
            exp_vec = 20'hC0000;
            p_vis = 0; p_in = 0; p_hs = 1; p_vs = 1; p_x = 0; p_y = 0;
            m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1; m_mode = 0;
        end else begin
            exp_vec = {p_hs, p_vs, p_vis, ev, colour(p_vis, p_in, p_x, p_y, m_mode)};
            p_vis = (h >= 1 && h <= 640 && v >= 1 && v <= 480);
            p_x   = h - 1;
            p_y   = v - 1;
            p_in  = (p_x >= m_bx && p_x < m_bx + BOX && p_y >= m_by && p_y < m_by + BOX);
            p_hs  = hs_in;
            p_vs  = vs_in;
            if (ev) begin
                m_mode = int'(mode);
                if (!frz) begin
                    if (m_dx) begin
                        if (m_bx + SX >= MAXX) begin m_bx = MAXX; m_dx = 0; end
                        else m_bx += SX;
                    end else if (m_bx <= SX) begin m_bx = 0; m_dx = 1; end
                    else m_bx -= SX;
                    if (m_dy) begin
                        if (m_by + SY >= MAXY) begin m_by = MAXY; m_dy = 0; end
                        else m_by += SY;
                    end else if (m_by <= SY) begin m_by = 0; m_dy = 1; end
                    else m_by -= SY;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_px(input int h, input int v);
        hc = 10'(h);
        vc = 10'(v);
    endtask

    task automatic test_reset();
        rst = 1'b1; set_px(0, 0);
        tick();
        if (dut_vec !== 20'hC0000) begin
            errors++; $display("FAIL reset_outputs got=%h want=%h", dut_vec, 20'hC0000);
        end
        checks++;
        if ({dut.box_x_q, dut.box_y_q, dut.dir_x_q, dut.dir_y_q} !== {20'd0, 2'b11}) begin
            errors++; $display("FAIL reset_sprite got=%0d,%0d,%b,%b want=0,0,1,1",
                               dut.box_x_q, dut.box_y_q, dut.dir_x_q, dut.dir_y_q);
        end
        checks++;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL reset_idle got=%h want=%h", dut_vec, exp_vec);
            end
            checks++;
        end
    endtask

    task automatic test_mode0();
        int hs_tab [5] = '{1, 33, 641, 0, 0};
        mode = 2'd0; frz = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_px(hs_tab[i], (i < 3) ? 1 : 0);
            tick();
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL mode0_px%0d got=%h want=%h", i, dut_vec, exp_vec);
            end
            checks++;
            if (i == 1 && {DataEnable, Red, Green, Blue} !== {1'b1, 16'hFFFF}) begin
                errors++; $display("FAIL mode0_box_white got=%b/%h want=1/ffff", DataEnable, {Red, Green, Blue});
            end
            if (i == 2 && {Red, Green, Blue} !== 16'h0000) begin
                errors++; $display("FAIL mode0_black got=%h want=0000", {Red, Green, Blue});
            end
            if (i == 3 && DataEnable !== 1'b0) begin
                errors++; $display("FAIL mode0_blank_de got=%b want=0", DataEnable);
            end
            if (i >= 1 && i <= 3) checks++;
        end
    endtask

    task automatic test_bars();
        int hs_tab [8];
        hs_tab = '{80, 81, 640, 0, 0, 0, 0, 0};
        for (int i = 3; i < 6; i++) hs_tab[i] = int'($urandom_range(1, 640));
        mode = 2'd1; frz = 1'b1;
        set_px(1, 481); tick();
        if (dut_vec !== exp_vec) begin
            errors++; $display("FAIL bars_event got=%h want=%h", dut_vec, exp_vec);
        end
        checks++;
        mode = 2'd0;
        for (int i = 0; i < 8; i++) begin
            set_px(hs_tab[i], (i < 6) ? 100 : 0);
            tick();
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL bars_px%0d got=%h want=%h", i, dut_vec, exp_vec);
            end
            checks++;
            if (i >= 1 && i <= 3) begin
                if ({Red, Green, Blue} !== bar_tab[(i == 1) ? 0 : (i == 2) ? 1 : 7]) begin
                    errors++; $display("FAIL bars_const%0d got=%h", i, {Red, Green, Blue});
                end
                checks++;
            end
        end
    endtask

    task automatic test_motion();
        int x, y;
        rst = 1'b1; set_px(0, 0); tick();
        rst = 1'b0; frz = 1'b0; mode = 2'd0;
        for (int n = 1; n <= 448; n++) begin
            set_px(1, 481); tick();
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL motion_event%0d got=%h want=%h", n, dut_vec, exp_vec);
            end
            checks++;
            if ({22'(dut.box_x_q), 22'(dut.box_y_q)} !== {22'(m_bx), 22'(m_by)}) begin
                errors++; $display("FAIL motion_pos%0d got=%0d,%0d want=%0d,%0d",
                                   n, dut.box_x_q, dut.box_y_q, m_bx, m_by);
            end
            checks++;
            if (n == 304 && {dut.box_x_q, dut.dir_x_q, dut.box_y_q} !== {10'd608, 1'b0, 10'd304}) begin
                errors++; $display("FAIL motion_304 got=%0d,%b,%0d want=608,0,304",
                                   dut.box_x_q, dut.dir_x_q, dut.box_y_q);
            end
            if (n == 305 && dut.box_x_q !== 10'd606) begin
                errors++; $display("FAIL motion_305 got=%0d want=606", dut.box_x_q);
            end
            if (n == 448 && {dut.box_y_q, dut.dir_y_q} !== {10'd448, 1'b0}) begin
                errors++; $display("FAIL motion_448 got=%0d,%b want=448,0", dut.box_y_q, dut.dir_y_q);
            end
            if (n == 304 || n == 305 || n == 448) checks++;
            for (int k = 0; k < 3; k++) begin
                x = m_bx + int'($urandom_range(0, BOX + 1)) - 1;
                y = m_by + int'($urandom_range(0, BOX + 1)) - 1;
                x = (x < 0) ? 0 : (x > 639) ? 639 : x;
                y = (y < 0) ? 0 : (y > 479) ? 479 : y;
                set_px(x + 1, y + 1); tick();
                if (dut_vec !== exp_vec) begin
                    errors++; $display("FAIL motion_px got=%h want=%h", dut_vec, exp_vec);
                end
                checks++;
            end
        end
    endtask

    task automatic test_mode_change();
        int pts [6][2] = '{'{17, 1}, '{1, 17}, '{1, 1}, '{0, 0}, '{0, 0}, '{0, 0}};
        mode = 2'd0; frz = 1'b0;
        set_px(1, 481); tick();
        set_px(320, 240); mode = 2'd2; tick();
        for (int i = 0; i < 20; i++) begin
            set_px(int'($urandom_range(1, 640)), int'($urandom_range(241, 480)));
            tick();
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL modechg_frame got=%h want=%h", dut_vec, exp_vec);
            end
            checks++;
        end
        set_px(1, 481); tick();
        for (int i = 0; i < 6; i++) begin
            set_px(pts[i][0], pts[i][1]); tick();
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL modechg_px%0d got=%h want=%h", i, dut_vec, exp_vec);
            end
            checks++;
            if ((i == 1 || i == 2) && m_bx > 64 && {DataEnable, Red, Green, Blue} !== {1'b1, 16'h0000}) begin
                errors++; $display("FAIL modechg_checker_black got=%b/%h", DataEnable, {Red, Green, Blue});
            end
            if ((i == 1 || i == 2) && m_bx > 64) checks++;
        end
    endtask

    task automatic test_sync();
        set_px(0, 490);
        for (int i = 0; i < 12; i++) begin
            hc = 10'(650 + i);
            hs_in = (i >= 6) ? 1'b0 : 1'b1;
            vs_in = (i >= 6) ? 1'b0 : 1'b1;
            tick();
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL sync_step%0d got=%h want=%h", i, dut_vec, exp_vec);
            end
            checks++;
            if ((i == 6 && {HSyncOut, VSyncOut} !== 2'b11) || (i == 7 && {HSyncOut, VSyncOut} !== 2'b00)) begin
                errors++; $display("FAIL sync_latency step%0d got=%b want=%b", i, {HSyncOut, VSyncOut}, (i == 6) ? 2'b11 : 2'b00);
            end
            if (i == 6 || i == 7) checks++;
        end
        hs_in = 1'b1; vs_in = 1'b1;
    endtask

    task automatic test_reset_midline();
        mode = 2'd3;
        set_px(400, 200); tick(); tick();
        rst = 1'b1; tick();
        if (dut_vec !== 20'hC0000 || {dut.box_x_q, dut.box_y_q} !== 20'd0) begin
            errors++; $display("FAIL midreset got=%h pos=%0d,%0d want=c0000 pos=0,0",
                               dut_vec, dut.box_x_q, dut.box_y_q);
        end
        checks++;
        set_px(1, 481); tick();
        if (dut_vec !== exp_vec || dut.mode_q !== 2'd0) begin
            errors++; $display("FAIL reset_event_ignored got=%h mode=%0d want=%h", dut_vec, dut.mode_q, exp_vec);
        end
        checks++;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_px(1 + i, 1); tick();
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL post_reset%0d got=%h want=%h", i, dut_vec, exp_vec);
            end
            checks++;
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) set_px(1, 481);
            else set_px(int'($urandom_range(0, 800)), int'($urandom_range(0, 525)));
            hs_in = 1'($urandom);
            vs_in = 1'($urandom);
            mode  = 2'($urandom);
            frz   = ($urandom_range(0, 3) == 0);
            rst   = ($urandom_range(0, 199) == 0);
            tick();
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL random_cycle%0d got=%h want=%h", i, dut_vec, exp_vec);
            end
            checks++;
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_bars();
        test_motion();
        test_mode_change();
        test_sync();
        test_reset_midline();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
